// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush controller: load-use and branch hazards, data-bus wait states
// with timeout abort, and a stall-cycle performance counter.
module pipe_hazard_ctrl #(
    parameter int unsigned TIMEOUT_CYC = 255,
    parameter int unsigned CNT_W       = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_uses_rs1,
    input  logic        id_uses_rs2,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_a_wr,
    input  logic        ex_branch_taken,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        stall_if,
    output logic        stall_id,
    output logic        stall_ex,
    output logic        stall_mem,
    output logic        flush_id,
    output logic        flush_ex,
    output logic        flush_wb,
    output logic        bus_err,
    output logic [1:0]  ctrl_state,
    output logic [31:0] stall_cycles
);

    localparam logic [1:0] StRun     = 2'd0;
    localparam logic [1:0] StMemWait = 2'd1;
    localparam logic [1:0] StAbort   = 2'd2;

    localparam logic [CNT_W-1:0] WaitLast = CNT_W'(TIMEOUT_CYC - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [31:0]      stall_cycles_q, stall_cycles_d;
    logic             mw, lu;

    assign mw = mem_req & ~mem_ready & (state_q != StAbort);
    assign lu = ex_mem_read & (ex_a_wr != 5'd0) &
                ((id_uses_rs1 & (id_rs1 == ex_a_wr)) | (id_uses_rs2 & (id_rs2 == ex_a_wr)));

    always_comb begin
        stall_if  = 1'b0;
        stall_id  = 1'b0;
        stall_ex  = 1'b0;
        stall_mem = 1'b0;
        flush_id  = 1'b0;
        flush_ex  = 1'b0;
        flush_wb  = 1'b0;
        bus_err   = 1'b0;
        if (rst) begin
            flush_id = 1'b1;
            flush_ex = 1'b1;
            flush_wb = 1'b1;
        end else if (mw) begin
            // EX is frozen, so branch and load-use are re-evaluated once the wait releases
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            stall_ex  = 1'b1;
            stall_mem = 1'b1;
            flush_wb  = 1'b1;
        end else begin
            if (state_q == StAbort) begin
                bus_err  = 1'b1;
                flush_wb = 1'b1;
            end
            if (ex_branch_taken) begin
                flush_id = 1'b1;
                flush_ex = 1'b1;
            end else if (lu) begin
                flush_ex = 1'b1;
                if (state_q != StAbort) begin
                    stall_if = 1'b1;
                    stall_id = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            StRun: begin
                if (mw) begin
                    state_d    = StMemWait;
                    wait_cnt_d = CNT_W'(1);
                end else begin
                    wait_cnt_d = '0;
                end
            end
            StMemWait: begin
                if (!mem_req || mem_ready) begin
                    state_d    = StRun;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WaitLast) begin
                    state_d    = StAbort;
                    wait_cnt_d = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d    = StRun;
                wait_cnt_d = '0;
            end
        endcase
    end

    assign stall_cycles_d = stall_cycles_q + 32'(stall_if);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StRun;
            wait_cnt_q     <= '0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            wait_cnt_q     <= wait_cnt_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign ctrl_state   = state_q;
    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed hazard/wait/timeout/reset/wrap steps
// followed by a randomized phase, all against a cycle-count-based reference model.
module tb_pipe_hazard_ctrl;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs1, id_rs2, ex_a_wr;
    logic        id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken;
    logic        mem_req, mem_ready;
    logic        stall_if, stall_id, stall_ex, stall_mem;
    logic        flush_id, flush_ex, flush_wb, bus_err;
    logic [1:0]  ctrl_state;
    logic [31:0] stall_cycles;

    pipe_hazard_ctrl #(.TIMEOUT_CYC(TO), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_mem_read(ex_mem_read), .ex_a_wr(ex_a_wr),
        .ex_branch_taken(ex_branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex), .stall_mem(stall_mem),
        .flush_id(flush_id), .flush_ex(flush_ex), .flush_wb(flush_wb),
        .bus_err(bus_err), .ctrl_state(ctrl_state), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: length of the current run of stalled memory cycles, abort flag, stall count
    int unsigned m_run   = 0;
    bit          m_abort = 1'b0;
    bit          m_valid = 1'b0;
    logic [31:0] m_cnt   = '0;

    task automatic chk(input string tag, input string name, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s.%s: observed %h expected %h", tag, name, obs, exp);
        end
    endtask

    task automatic set_idle();
        rst = 0; id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
        ex_mem_read = 0; ex_a_wr = 0; ex_branch_taken = 0; mem_req = 0; mem_ready = 0;
    endtask

    // Inputs are already applied (at negedge); check, clock, advance the model.
    task automatic cycle(input string tag);
        bit mw, lu, e_sif, e_sid, e_sex, e_smem, e_fid, e_fex, e_fwb, e_err;
        #1;
        lu = ex_mem_read && ex_a_wr != 0 &&
             ((id_uses_rs1 && id_rs1 == ex_a_wr) || (id_uses_rs2 && id_rs2 == ex_a_wr));
        mw = mem_req && !mem_ready && !m_abort;
        {e_sif, e_sid, e_sex, e_smem, e_fid, e_fex, e_fwb, e_err} = '0;
        if (rst) begin
            {e_fid, e_fex, e_fwb} = 3'b111;
        end else if (mw) begin
            {e_sif, e_sid, e_sex, e_smem, e_fwb} = 5'b11111;
        end else begin
            e_fwb = m_abort;
            e_err = m_abort;
            if (ex_branch_taken) begin
                e_fid = 1; e_fex = 1;
            end else if (lu) begin
                e_fex = 1;
                e_sif = !m_abort;
                e_sid = !m_abort;
            end
        end
        chk(tag, "stall_if", stall_if, e_sif);
        chk(tag, "stall_id", stall_id, e_sid);
        chk(tag, "stall_ex", stall_ex, e_sex);
        chk(tag, "stall_mem", stall_mem, e_smem);
        chk(tag, "flush_id", flush_id, e_fid);
        chk(tag, "flush_ex", flush_ex, e_fex);
        chk(tag, "flush_wb", flush_wb, e_fwb);
        chk(tag, "bus_err", bus_err, e_err);
        if (m_valid) begin
            chk(tag, "ctrl_state", ctrl_state, m_abort ? 2 : (m_run > 0 ? 1 : 0));
            chk(tag, "stall_cycles", stall_cycles, m_cnt);
        end
        @(posedge clk);
        if (rst) begin
            m_run = 0; m_abort = 0; m_cnt = 0; m_valid = 1;
        end else begin
            if (e_sif) m_cnt = m_cnt + 1;
            m_abort = 0;
            if (mw) begin
                m_run++;
                if (m_run == TO) begin
                    m_abort = 1;
                    m_run   = 0;
                end
            end else begin
                m_run = 0;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        set_idle();
        rst = 1;
        @(negedge clk);
        cycle("reset0");
        cycle("reset1");
        rst = 0;
        cycle("idle");

        // Load-use on rs2, then same pattern targeting x0
        ex_mem_read = 1; ex_a_wr = 5; id_rs2 = 5; id_uses_rs2 = 1;
        cycle("lu");
        set_idle();
        cycle("lu_after");
        chk("lu_after", "count", stall_cycles, 32'd1);
        ex_mem_read = 1; ex_a_wr = 0; id_rs2 = 0; id_uses_rs2 = 1;
        cycle("lu_x0");
        set_idle();

        // Branch together with a load-use on rs1
        ex_mem_read = 1; ex_a_wr = 7; id_rs1 = 7; id_uses_rs1 = 1; ex_branch_taken = 1;
        cycle("br_lu");
        set_idle();
        cycle("br_after");

        // Three wait states; branch held during the wait, acted on at release
        mem_req = 1;
        cycle("wait1");
        ex_branch_taken = 1;
        cycle("wait2");
        cycle("wait3");
        mem_ready = 1;
        cycle("wait_rel");
        set_idle();
        cycle("wait_done");
        chk("wait_done", "count", stall_cycles, 32'd4);

        // Timeout, abort, then a new wait while the request stays high
        mem_req = 1;
        for (int i = 0; i < 7; i++) cycle("timeout");
        mem_ready = 1;
        cycle("to_rel");
        set_idle();

        // Abort cycle with a load-use present: flush_ex only, no stall
        mem_req = 1;
        for (int i = 0; i < TO; i++) cycle("to2");
        ex_mem_read = 1; ex_a_wr = 3; id_rs1 = 3; id_uses_rs1 = 1;
        cycle("abort_lu");
        set_idle();
        cycle("abort_lu_after");

        // Reset in the second MEM_WAIT cycle
        mem_req = 1;
        cycle("rw1");
        cycle("rw2");
        rst = 1;
        cycle("rw_rst");
        rst = 0; mem_req = 0;
        cycle("rw_after");
        chk("rw_after", "count", stall_cycles, 32'd0);

        // Counter wrap
        force dut.stall_cycles_q = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cycles_q;
        m_cnt = 32'hFFFF_FFFE;
        ex_mem_read = 1; ex_a_wr = 9; id_rs2 = 9; id_uses_rs2 = 1;
        cycle("wrap1");
        cycle("wrap2");
        set_idle();
        cycle("wrap_done");
        chk("wrap_done", "count", stall_cycles, 32'd0);

        // Randomized phase
        for (int i = 0; i < 600; i++) begin
            rst             = ($urandom_range(0, 59) == 0);
            id_rs1          = 5'($urandom_range(0, 3));
            id_rs2          = 5'($urandom_range(0, 3));
            ex_a_wr         = 5'($urandom_range(0, 3));
            id_uses_rs1     = 1'($urandom_range(0, 1));
            id_uses_rs2     = 1'($urandom_range(0, 1));
            ex_mem_read     = 1'($urandom_range(0, 1));
            ex_branch_taken = ($urandom_range(0, 4) == 0);
            mem_req         = ($urandom_range(0, 3) != 0);
            mem_ready       = ($urandom_range(0, 3) == 0);
            cycle("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
